// File: rtl/cpu_bus_master.sv
// 8088 minimum-mode bus initiator: turns single transfer requests into T1..T4
// cycles on a multiplexed 8-bit bus, with READY wait states and a timeout.
module cpu_bus_master #(
  parameter int READY_TIMEOUT = 255
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq,
  input  logic [2:0]  iKind,
  input  logic [19:0] iAddr,
  input  logic [7:0]  iData,
  output logic [7:0]  oData,
  output logic        oDone,
  output logic        oErr,
  output logic        oBusy,
  output logic        oBusClk,
  output logic        oAle,
  output logic [11:0] oAddr,
  output logic [7:0]  oAd,
  output logic        oAdOe,
  input  logic [7:0]  iAd,
  output logic        oIom,
  output logic        oDtr,
  output logic        oSso,
  output logic        oRdN,
  output logic        oWrN,
  output logic        oIntaN,
  output logic        oDenN,
  input  logic        iReady
);

  typedef enum logic [3:0] {
    S_IDLE, S_PEND, S_ERR,
    S_T1L, S_T1H, S_T2L, S_T2H, S_T3L, S_T3H, S_TWL, S_TWH, S_T4L, S_T4H
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  kind_reg;
  logic [19:0] addr_reg;
  logic [7:0]  data_reg;
  logic [7:0]  wait_cnt_reg;

  logic        accept;
  logic        timeout_hit;
  logic [2:0]  kind_eff;
  logic [19:0] addr_eff;
  logic [7:0]  data_eff;
  logic        is_write, is_inta;
  logic        in_bus, addr_ph, strobe_ph, den_ph;

  // Outputs are registered from the next state, so a request accepted in IDLE
  // must be decoded from the live inputs rather than the latched copy.
  always_comb begin
    accept     = iReq && !oBusy;
    kind_eff   = accept ? iKind : kind_reg;
    addr_eff   = accept ? iAddr : addr_reg;
    data_eff   = accept ? iData : data_reg;
    is_write   = kind_eff[1] && !kind_eff[0];
    is_inta    = (kind_eff == 3'b100);
    timeout_hit = 1'b0;
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (iKind[1:0] == 2'b11) state_next = S_ERR;
          else if (oBusClk)        state_next = S_T1L;
          else                     state_next = S_PEND;
        end
      end
      S_PEND: state_next = S_T1L;
      S_ERR:  state_next = S_IDLE;
      S_T1L:  state_next = S_T1H;
      S_T1H:  state_next = S_T2L;
      S_T2L:  state_next = S_T2H;
      S_T2H:  state_next = S_T3L;
      S_T3L:  state_next = S_T3H;
      S_T3H:  state_next = iReady ? S_T4L : S_TWL;
      S_TWL:  state_next = S_TWH;
      S_TWH: begin
        if (iReady) begin
          state_next = S_T4L;
        end else if (({1'b0, wait_cnt_reg} + 9'd1) == 9'(READY_TIMEOUT)) begin
          state_next  = S_T4L;
          timeout_hit = 1'b1;
        end else begin
          state_next = S_TWL;
        end
      end
      S_T4L:  state_next = S_T4H;
      S_T4H:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    in_bus    = state_next inside {[S_T1L:S_T4H]};
    addr_ph   = state_next inside {S_T1L, S_T1H};
    strobe_ph = state_next inside {S_T2L, S_T2H, S_T3L, S_T3H, S_TWL, S_TWH};
    // Writes enable the transceiver a half clock earlier and hold it through T4L.
    if (is_write) den_ph = strobe_ph || (state_next == S_T4L);
    else          den_ph = state_next inside {S_T2H, S_T3L, S_T3H, S_TWL, S_TWH};
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_reg    <= S_IDLE;
      kind_reg     <= 3'b011;
      addr_reg     <= '0;
      data_reg     <= '0;
      wait_cnt_reg <= '0;
      oData        <= '0;
      oDone        <= 1'b0;
      oErr         <= 1'b0;
      oBusy        <= 1'b0;
      oBusClk      <= 1'b0;
      oAle         <= 1'b0;
      oAddr        <= '0;
      oAd          <= '0;
      oAdOe        <= 1'b0;
      {oIom, oDtr, oSso} <= 3'b011;
      oRdN         <= 1'b1;
      oWrN         <= 1'b1;
      oIntaN       <= 1'b1;
      oDenN        <= 1'b1;
    end else begin
      state_reg <= state_next;
      oBusClk   <= ~oBusClk;
      oBusy     <= (state_next != S_IDLE);

      if (accept) begin
        kind_reg <= iKind;
        addr_reg <= iAddr;
        data_reg <= iData;
      end

      if (state_reg == S_TWH)      wait_cnt_reg <= wait_cnt_reg + 8'd1;
      else if (state_reg != S_TWL) wait_cnt_reg <= '0;

      oDone <= (state_next == S_T4L) || (state_next == S_ERR);
      oErr  <= ((state_next == S_T4L) && timeout_hit) || (state_next == S_ERR);

      if ((state_next == S_T4L) && !is_write)
        oData <= timeout_hit ? 8'hFF : iAd;

      oAle  <= (state_next == S_T1L);
      oAddr <= in_bus ? addr_eff[19:8] : 12'h000;
      {oIom, oDtr, oSso} <= in_bus ? kind_eff : 3'b011;

      if (addr_ph) begin
        oAd   <= addr_eff[7:0];
        oAdOe <= 1'b1;
      end else if (in_bus && is_write) begin
        oAd   <= data_eff;
        oAdOe <= 1'b1;
      end else begin
        oAd   <= 8'h00;
        oAdOe <= 1'b0;
      end

      oRdN   <= !(strobe_ph && !is_write && !is_inta);
      oIntaN <= !(strobe_ph && is_inta);
      oWrN   <= !(strobe_ph && is_write);
      oDenN  <= !den_ph;
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: directed test-plan transfers plus random transfers,
// each summarised by phase counts and checked against spec-derived arithmetic.
module tb_cpu_bus_master;
  localparam int TO = 4;

  logic        iClk = 1'b0;
  logic        iRst, iReq, iReady;
  logic [2:0]  iKind;
  logic [19:0] iAddr;
  logic [7:0]  iData, iAd;
  logic [7:0]  oData, oAd;
  logic        oDone, oErr, oBusy, oBusClk, oAle, oAdOe;
  logic [11:0] oAddr;
  logic        oIom, oDtr, oSso, oRdN, oWrN, oIntaN, oDenN;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_data;
  logic [2:0] valid_kinds [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

  always #5 iClk = ~iClk;

  cpu_bus_master #(.READY_TIMEOUT(TO)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iKind(iKind), .iAddr(iAddr),
    .iData(iData), .oData(oData), .oDone(oDone), .oErr(oErr), .oBusy(oBusy),
    .oBusClk(oBusClk), .oAle(oAle), .oAddr(oAddr), .oAd(oAd), .oAdOe(oAdOe),
    .iAd(iAd), .oIom(oIom), .oDtr(oDtr), .oSso(oSso), .oRdN(oRdN), .oWrN(oWrN),
    .oIntaN(oIntaN), .oDenN(oDenN), .iReady(iReady)
  );

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while (oBusy && guard < 60) begin
      step();
      guard++;
    end
    checks++;
    if (oBusy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_wait busy=%b required 0", name, oBusy);
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iReq = 1'b0; iReady = 1'b1; iKind = 3'b000;
    iAddr = '0; iData = '0; iAd = '0;
    repeat (3) step();
    checks++;
    if ({oBusClk, oAle, oAddr, oAd, oAdOe, oData, oDone, oErr, oBusy,
         oIom, oDtr, oSso, oRdN, oWrN, oIntaN, oDenN} !==
        {1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
         3'b011, 4'b1111}) begin
      errors++;
      $display("FAIL reset_values busclk=%b ale=%b addr=%h ad=%h oe=%b data=%h done=%b err=%b busy=%b st=%b%b%b rd=%b wr=%b inta=%b den=%b required all-idle",
               oBusClk, oAle, oAddr, oAd, oAdOe, oData, oDone, oErr, oBusy,
               oIom, oDtr, oSso, oRdN, oWrN, oIntaN, oDenN);
    end
    iRst = 1'b0;
    exp_data = 8'h00;
    step();
    checks++;
    if (oBusClk !== 1'b1) begin
      errors++;
      $display("FAIL busclk_toggle got %b required 1", oBusClk);
    end
    step();
    $display("reset done");
  endtask

  // One bus transfer; nlow = number of READY samples held low before the first high one.
  task automatic run_xfer(input string name, input logic [2:0] kind, input logic [19:0] addr,
                          input logic [7:0] data, input int nlow, input logic [7:0] ad_val,
                          input bit extra_req, input int post);
    int lat, len, w, t, i, k, end_idx, den_first, done_idx;
    int ale_cnt, ale_bad, stat_bad, bc_bad, rd_lo, wr_lo, inta_lo, den_lo;
    int adoe_cnt, adwr_bad, done_cnt, stray_err, idle_bad;
    int exp_rd, exp_wr, exp_inta, exp_den, exp_den_first;
    bit rd, inta, err_exp, done_err;
    logic exp_bc;

    wait_idle(name);
    rd = !(kind[1] && !kind[0]);
    inta = (kind == 3'b100);
    w = (nlow < TO) ? nlow : TO;
    err_exp = (nlow > TO);
    len = 8 + 2 * w;
    ale_cnt = 0; ale_bad = 0; stat_bad = 0; bc_bad = 0; rd_lo = 0; wr_lo = 0;
    inta_lo = 0; den_lo = 0; adoe_cnt = 0; adwr_bad = 0; done_cnt = 0;
    stray_err = 0; idle_bad = 0; end_idx = -1; den_first = -1; done_idx = -1;
    done_err = 1'b0;

    iKind = kind; iAddr = addr; iData = data; iReq = 1'b1;
    iAd = $urandom; iReady = 1'($urandom_range(0, 1));
    lat = oBusClk ? 1 : 2;
    t = 0;
    while (t < lat + len + post) begin
      step();
      t++;
      if (t == 1) iReq = 1'b0;
      i = t - lat;
      if (extra_req && i == 3) begin
        iReq = 1'b1;
        iKind = valid_kinds[$urandom_range(0, 5)];
        iAddr = $urandom;
      end else if (extra_req && i == 4) begin
        iReq = 1'b0;
      end

      if (i >= 0 && i < len) begin
        exp_bc = ((i % 2) == 1);
        if (oBusClk !== exp_bc) bc_bad++;
        if ({oIom, oDtr, oSso} !== kind || oAddr !== addr[19:8]) stat_bad++;
        if (!oRdN) rd_lo++;
        if (!oWrN) wr_lo++;
        if (!oIntaN) inta_lo++;
        if (!oDenN) begin
          den_lo++;
          if (den_first < 0) den_first = i;
        end
        if (oAdOe) begin
          adoe_cnt++;
          if (i >= 2 && oAd !== data) adwr_bad++;
        end
      end else begin
        if (!oRdN || !oWrN || !oIntaN || !oDenN || oAdOe || {oIom, oDtr, oSso} !== 3'b011)
          idle_bad++;
      end
      if (oAle) begin
        ale_cnt++;
        if (i != 0 || oAddr !== addr[19:8] || oAd !== addr[7:0] || oAdOe !== 1'b1) ale_bad++;
      end
      if (oDone) begin
        done_cnt++;
        done_idx = i;
        done_err = oErr;
      end else if (oErr) begin
        stray_err++;
      end
      if (end_idx < 0 && i >= 0 && !oBusy) end_idx = i;

      // READY is sampled at the end of T3H and every TWH: phase 5 + 2k.
      if (i >= 5 && ((i - 5) % 2) == 0) begin
        k = (i - 5) / 2;
        iReady = (k >= nlow);
        iAd = (k == nlow) ? ad_val : ~ad_val;
      end else begin
        iReady = 1'($urandom_range(0, 1));
        iAd = $urandom;
      end
    end

    exp_rd   = (rd && !inta) ? 4 + 2 * w : 0;
    exp_inta = inta ? 4 + 2 * w : 0;
    exp_wr   = rd ? 0 : 4 + 2 * w;
    exp_den  = rd ? 3 + 2 * w : 5 + 2 * w;
    exp_den_first = rd ? 3 : 2;
    if (rd) exp_data = err_exp ? 8'hFF : ad_val;

    checks++;
    if (ale_cnt != 1 || ale_bad != 0) begin
      errors++;
      $display("FAIL %s ale count=%0d bad=%0d required count=1 bad=0", name, ale_cnt, ale_bad);
    end
    checks++;
    if (stat_bad != 0) begin
      errors++;
      $display("FAIL %s status bad_cycles=%0d required 0", name, stat_bad);
    end
    checks++;
    if (bc_bad != 0) begin
      errors++;
      $display("FAIL %s busclk bad_cycles=%0d required 0", name, bc_bad);
    end
    checks++;
    if (rd_lo != exp_rd || wr_lo != exp_wr || inta_lo != exp_inta) begin
      errors++;
      $display("FAIL %s strobes rd/wr/inta=%0d/%0d/%0d required %0d/%0d/%0d",
               name, rd_lo, wr_lo, inta_lo, exp_rd, exp_wr, exp_inta);
    end
    checks++;
    if (den_lo != exp_den || den_first != exp_den_first) begin
      errors++;
      $display("FAIL %s den low=%0d first=%0d required %0d first=%0d",
               name, den_lo, den_first, exp_den, exp_den_first);
    end
    checks++;
    if (adoe_cnt != (rd ? 2 : len) || adwr_bad != 0) begin
      errors++;
      $display("FAIL %s ad_drive oe_cycles=%0d bad_data=%0d required %0d bad=0",
               name, adoe_cnt, adwr_bad, rd ? 2 : len);
    end
    checks++;
    if (done_cnt != 1 || done_idx != 6 + 2 * w) begin
      errors++;
      $display("FAIL %s done count=%0d phase=%0d required 1 phase=%0d",
               name, done_cnt, done_idx, 6 + 2 * w);
    end
    checks++;
    if (done_err !== err_exp || stray_err != 0) begin
      errors++;
      $display("FAIL %s err got=%b stray=%0d required %b stray=0", name, done_err, stray_err, err_exp);
    end
    checks++;
    if (end_idx != len) begin
      errors++;
      $display("FAIL %s busy_drop phase=%0d required %0d", name, end_idx, len);
    end
    checks++;
    if (oData !== exp_data) begin
      errors++;
      $display("FAIL %s data got=%h required %h", name, oData, exp_data);
    end
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL %s passive bad_cycles=%0d required 0", name, idle_bad);
    end
    $display("xfer %s kind=%b addr=%h wdata=%h waits=%0d err=%0b data=%h",
             name, kind, addr, data, w, err_exp, oData);
  endtask

  task automatic test_test_plan();
    run_xfer("mem_rd", 3'b001, 20'hABCDE, 8'h00, 0, 8'h5A, 1'b0, 3);
    run_xfer("io_wr", 3'b110, 20'h003F8, 8'h41, 0, 8'h00, 1'b0, 3);
    run_xfer("mem_rd_wait3", 3'b001, 20'h12345, 8'h00, 3, 8'hA7, 1'b0, 3);
    run_xfer("mem_rd_timeout", 3'b001, 20'h54321, 8'h00, 50, 8'h33, 1'b0, 3);
    run_xfer("inta", 3'b100, 20'h00000, 8'h00, 1, 8'h08, 1'b0, 3);
    run_xfer("wr_timeout", 3'b010, 20'hFFFFF, 8'h99, 9, 8'h00, 1'b0, 3);
  endtask

  task automatic test_invalid();
    logic [2:0] bad_kind;
    wait_idle("invalid");
    bad_kind = $urandom_range(0, 1) ? 3'b111 : 3'b011;
    iKind = bad_kind; iAddr = $urandom; iData = $urandom; iReq = 1'b1;
    step();
    iReq = 1'b0;
    checks++;
    if (!(oDone === 1'b1 && oErr === 1'b1) || oAle !== 1'b0 ||
        {oRdN, oWrN, oIntaN, oDenN} !== 4'b1111 || {oIom, oDtr, oSso} !== 3'b011) begin
      errors++;
      $display("FAIL invalid_pulse done=%b err=%b ale=%b strobes=%b%b%b%b st=%b%b%b required 1 1 0 1111 011",
               oDone, oErr, oAle, oRdN, oWrN, oIntaN, oDenN, oIom, oDtr, oSso);
    end
    step();
    checks++;
    if (oDone !== 1'b0 || oErr !== 1'b0 || oBusy !== 1'b0 || oData !== exp_data) begin
      errors++;
      $display("FAIL invalid_after done=%b err=%b busy=%b data=%h required 0 0 0 %h",
               oDone, oErr, oBusy, oData, exp_data);
    end
    $display("xfer invalid kind=%b", bad_kind);
  endtask

  task automatic test_reset_mid();
    int lat, dn, al;
    wait_idle("reset_mid");
    iKind = 3'b010; iAddr = 20'h2468A; iData = 8'hC3; iReq = 1'b1; iReady = 1'b1;
    lat = oBusClk ? 1 : 2;
    for (int t = 1; t <= lat + 4; t++) begin
      step();
      iReq = 1'b0;
    end
    checks++;
    if (oWrN !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_t3l wr_n=%b required 0", oWrN);
    end
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    exp_data = 8'h00;
    checks++;
    if ({oWrN, oDenN, oAdOe, oIom, oDtr, oSso, oBusy, oDone, oErr, oBusClk, oData} !==
        {1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_edge wr=%b den=%b oe=%b st=%b%b%b busy=%b done=%b err=%b bc=%b data=%h required 1 1 0 011 0 0 0 0 00",
               oWrN, oDenN, oAdOe, oIom, oDtr, oSso, oBusy, oDone, oErr, oBusClk, oData);
    end
    dn = 0; al = 0;
    repeat (20) begin
      step();
      if (oDone) dn++;
      if (oAle) al++;
    end
    checks++;
    if (dn != 0 || al != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet done=%0d ale=%0d required 0 0", dn, al);
    end
    $display("xfer reset_mid write aborted in T3L");
  endtask

  task automatic test_back_to_back();
    run_xfer("b2b_first", 3'b101, 20'h0F0F0, 8'h00, 0, 8'h6C, 1'b1, 0);
    checks++;
    if (oBusClk !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_busclk got %b required 0", oBusClk);
    end
    run_xfer("b2b_second", 3'b010, 20'h13579, 8'hE1, 2, 8'h00, 1'b0, 0);
    run_xfer("b2b_third", 3'b000, 20'h8ACE0, 8'h00, 1, 8'h2F, 1'b1, 4);
  endtask

  task automatic test_random();
    for (int n = 0; n < 14; n++) begin
      run_xfer("rand", valid_kinds[$urandom_range(0, 5)], 20'($urandom), 8'($urandom),
               $urandom_range(0, 6), 8'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_test_plan();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    test_invalid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
